// File: rtl/mulu.sv
// Sequential unsigned fixed-point multiplier: shift-add, one multiplier bit per cycle.
// Optional round-half-up on the fractional cut is enabled by defining MULU_ROUND_EN.
module mulu #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned FBITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             valid,
    output logic             ovf,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] val
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CntW  = $clog2(WIDTH + 1);
    localparam int unsigned RndSh = (FBITS > 0) ? FBITS - 1 : 0;
    localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

`ifdef MULU_ROUND_EN
    localparam logic [PW-1:0] RndAdd = (FBITS > 0) ? (PW'(1) << RndSh) : '0;
`else
    localparam logic [PW-1:0] RndAdd = '0;
`endif

    typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

    state_e            state_q;
    logic [PW-1:0]     acc_q;
    logic [PW-1:0]     mcand_q;
    logic [WIDTH-1:0]  mplier_q;
    logic [CntW-1:0]   cnt_q;
    logic              busy_q, done_q, valid_q, ovf_q;
    logic [WIDTH-1:0]  val_q;

    logic [PW-1:0]     p_rnd;
    logic [PW-1:0]     p_hi;
    logic [WIDTH-1:0]  p_res;

    // Max product plus the rounding constant still fits in PW bits, so no carry is lost.
    always_comb begin
        p_rnd = acc_q + RndAdd;
        p_hi  = p_rnd >> (WIDTH + FBITS);
        p_res = WIDTH'(p_rnd >> FBITS);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            val_q    <= '0;
        end else if (start) begin
            // A zero operand goes straight to FIN with an all-zero accumulator.
            state_q  <= ((a == '0) || (b == '0)) ? StFin : StCalc;
            acc_q    <= '0;
            mcand_q  <= PW'(a);
            mplier_q <= b;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            val_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StCalc: begin
                    acc_q    <= acc_q + (mplier_q[0] ? mcand_q : '0);
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LastIter) begin
                        state_q <= StFin;
                    end
                end
                StFin: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    if (p_hi != '0) begin
                        ovf_q   <= 1'b1;
                        valid_q <= 1'b0;
                        val_q   <= '0;
                    end else begin
                        ovf_q   <= 1'b0;
                        valid_q <= 1'b1;
                        val_q   <= p_res;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign valid = valid_q;
    assign ovf   = ovf_q;
    assign val   = val_q;

endmodule

// File: tb/tb_mulu.sv
// Directed-vector bench for mulu at WIDTH=8, FBITS=4; expected values are hand-computed.
module tb_mulu;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy, done, valid, ovf;
    logic [7:0] a, b, val;

    int n_cmp = 0;
    int n_err = 0;

    mulu #(.WIDTH(8), .FBITS(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .busy  (busy),
        .done  (done),
        .valid (valid),
        .ovf   (ovf),
        .a     (a),
        .b     (b),
        .val   (val)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running required finished");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start at edge N, then count edges until done; busy must stay high until done.
    task automatic run_mul(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                           input logic [7:0] ev, input logic evalid, input logic eovf,
                           input int elat);
        int  lat;
        bit  busy_ok;
        logic [7:0] held;
        a = ia;
        b = ib;
        start = 1'b1;
        tick();
        start = 1'b0;
        a = ~ia;
        b = ~ib;
        check_eq({tag, ".busy_at_start"}, 32'(busy), 32'd1);
        lat = 0;
        busy_ok = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (done) begin
                lat = k;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
        check_eq({tag, ".latency"}, 32'(lat), 32'(elat));
        check_eq({tag, ".busy_held"}, 32'(busy_ok), 32'd1);
        check_eq({tag, ".val"}, 32'(val), 32'(ev));
        check_eq({tag, ".valid"}, 32'(valid), 32'(evalid));
        check_eq({tag, ".ovf"}, 32'(ovf), 32'(eovf));
        check_eq({tag, ".busy_at_done"}, 32'(busy), 32'd0);
        held = val;
        tick();
        tick();
        check_eq({tag, ".done_pulse"}, 32'(done), 32'd0);
        check_eq({tag, ".val_hold"}, 32'(val), 32'(ev));
        check_eq({tag, ".held_same"}, 32'(val), 32'(held));
    endtask

    initial begin
        int  dones;
        int  done_at;
        logic [7:0] rnd_exp;

        rst = 1'b1;
        start = 1'b0;
        a = 8'h00;
        b = 8'h00;
        tick();
        tick();
        check_eq("reset.busy", 32'(busy), 32'd0);
        check_eq("reset.done", 32'(done), 32'd0);
        check_eq("reset.valid", 32'(valid), 32'd0);
        check_eq("reset.ovf", 32'(ovf), 32'd0);
        check_eq("reset.val", 32'(val), 32'd0);

        // rst wins over start
        start = 1'b1;
        a = 8'h18;
        b = 8'h20;
        tick();
        check_eq("rst_prio.busy", 32'(busy), 32'd0);
        start = 1'b0;
        rst = 1'b0;
        tick();

        run_mul("m1p5x2", 8'h18, 8'h20, 8'h30, 1'b1, 1'b0, 9);
        run_mul("ovf80x20", 8'h80, 8'h20, 8'h00, 1'b0, 1'b1, 9);
        run_mul("ovfFFx11", 8'hFF, 8'h11, 8'h00, 1'b0, 1'b1, 9);
        run_mul("maxFFx10", 8'hFF, 8'h10, 8'hFF, 1'b1, 1'b0, 9);
        run_mul("m0Fx0F", 8'h0F, 8'h0F, 8'h0E, 1'b1, 1'b0, 9);
`ifdef MULU_ROUND_EN
        rnd_exp = 8'h01;
`else
        rnd_exp = 8'h00;
`endif
        run_mul("round01x08", 8'h01, 8'h08, rnd_exp, 1'b1, 1'b0, 9);
        run_mul("zero_a", 8'h00, 8'h55, 8'h00, 1'b1, 1'b0, 1);
        run_mul("zero_b", 8'h33, 8'h00, 8'h00, 1'b1, 1'b0, 1);

        // Reset at edge N+4 aborts without a done pulse
        a = 8'h18;
        b = 8'h20;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("abort.busy", 32'(busy), 32'd0);
        check_eq("abort.done", 32'(done), 32'd0);
        check_eq("abort.valid", 32'(valid), 32'd0);
        check_eq("abort.ovf", 32'(ovf), 32'd0);
        check_eq("abort.val", 32'(val), 32'd0);
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done) dones++;
        end
        check_eq("abort.no_done", 32'(dones), 32'd0);
        run_mul("after_abort", 8'h18, 8'h20, 8'h30, 1'b1, 1'b0, 9);

        // Second start at edge N+3 restarts; single done at N+12
        a = 8'h18;
        b = 8'h20;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        a = 8'h10;
        b = 8'h10;
        start = 1'b1;
        tick();
        start = 1'b0;
        a = 8'hAA;
        b = 8'hAA;
        dones = 0;
        done_at = 0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (done) begin
                dones++;
                done_at = k + 3;
            end
        end
        check_eq("restart.done_count", 32'(dones), 32'd1);
        check_eq("restart.done_edge", 32'(done_at), 32'd12);
        check_eq("restart.val", 32'(val), 32'h10);
        check_eq("restart.valid", 32'(valid), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
